// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with redirect, trap, stall and halt/resume
// Fetch PC is offered with a valid/ready handshake and advanced on each accepted fetch.
module pc_sequencer #(
   parameter int              XLEN         = 32,
   parameter int              INC          = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0004,
   parameter int              ALIGN_BITS   = 2
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            stall,
   input  logic            fetch_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_tgt,
   input  logic            trap_req,
   input  logic            halt_req,
   input  logic            resume_req,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic [XLEN-1:0] pc_plus,
   output logic [XLEN-1:0] last_pc,
   output logic            misalign_err,
   output logic            halted
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_e;

   // A zero ALIGN_BITS yields an all-zero mask, which disables the check.
   localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);

   state_e          state_q;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] last_pc_q;
   logic            pc_valid_q;
   logic            halted_q;
   logic            misalign_q, misalign_d;
   logic            accept;
   logic            tgt_misaligned;

   assign pc_plus        = pc_q + XLEN'(INC);
   assign accept         = pc_valid_q & fetch_ready & ~stall;
   assign tgt_misaligned = |(redirect_tgt & ALIGN_MASK);

   always_comb begin
      pc_d       = pc_q;
      misalign_d = 1'b0;
      if (trap_req) begin
         pc_d = TRAP_VECTOR;
      end else if (redirect_valid && tgt_misaligned) begin
         pc_d       = TRAP_VECTOR;
         misalign_d = 1'b1;
      end else if (redirect_valid) begin
         pc_d = redirect_tgt;
      end else if (accept) begin
         pc_d = pc_plus;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_VECTOR;
         last_pc_q  <= RESET_VECTOR;
         pc_valid_q <= 1'b0;
         halted_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            S_BOOT: begin
               state_q    <= S_RUN;
               pc_valid_q <= 1'b1;
            end
            S_RUN: begin
               pc_q       <= pc_d;
               misalign_q <= misalign_d;
               if (accept) last_pc_q <= pc_q;
               // Halt takes effect after this cycle's PC update has been applied.
               if (halt_req) begin
                  state_q    <= S_HALT;
                  pc_valid_q <= 1'b0;
                  halted_q   <= 1'b1;
               end
            end
            S_HALT: begin
               if (trap_req) begin
                  pc_q       <= TRAP_VECTOR;
                  state_q    <= S_RUN;
                  pc_valid_q <= 1'b1;
                  halted_q   <= 1'b0;
               end else if (resume_req) begin
                  state_q    <= S_RUN;
                  pc_valid_q <= 1'b1;
                  halted_q   <= 1'b0;
               end
            end
            default: begin
               state_q    <= S_BOOT;
               pc_valid_q <= 1'b0;
               halted_q   <= 1'b0;
            end
         endcase
      end
   end

   assign pc           = pc_q;
   assign pc_valid     = pc_valid_q;
   assign last_pc      = last_pc_q;
   assign misalign_err = misalign_q;
   assign halted       = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        stall = 1'b0;
   logic        fetch_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_tgt = '0;
   logic        trap_req = 1'b0;
   logic        halt_req = 1'b0;
   logic        resume_req = 1'b0;
   logic [31:0] pc, pc_plus, last_pc;
   logic        pc_valid, misalign_err, halted;

   int checks = 0;
   int errors = 0;

   pc_sequencer dut (
      .CLK(CLK), .RST_N(RST_N), .stall(stall), .fetch_ready(fetch_ready),
      .redirect_valid(redirect_valid), .redirect_tgt(redirect_tgt),
      .trap_req(trap_req), .halt_req(halt_req), .resume_req(resume_req),
      .pc(pc), .pc_valid(pc_valid), .pc_plus(pc_plus), .last_pc(last_pc),
      .misalign_err(misalign_err), .halted(halted)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic redirect_to(input logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_tgt   = tgt;
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      // T1: reset state and first fetches
      fetch_ready = 1'b1;
      #2;
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'b0, pc_valid}, 32'd0);
      check("rst_last", last_pc, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_mis", {31'b0, misalign_err}, 32'd0);
      tick();
      tick();
      RST_N = 1'b1;
      check("boot_valid", {31'b0, pc_valid}, 32'd0);
      tick();
      check("run_valid", {31'b0, pc_valid}, 32'd1);
      check("t1_pc0", pc, 32'h0);
      tick();
      check("t1_pc4", pc, 32'h4);
      check("t1_last0", last_pc, 32'h0);
      tick();
      check("t1_pc8", pc, 32'h8);
      check("t1_plus", pc_plus, 32'hC);

      // T2: stall then not-ready hold the PC
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_stall_pc", pc, 32'h8);
         check("t2_stall_last", last_pc, 32'h4);
      end
      stall = 1'b0;
      fetch_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t2_nrdy_pc", pc, 32'h8);
      end
      fetch_ready = 1'b1;
      tick();
      check("t2_rel_pc", pc, 32'hC);
      check("t2_rel_last", last_pc, 32'h8);

      // T3: redirect under stall, misaligned redirect
      tick();
      check("t3_pc10", pc, 32'h10);
      stall = 1'b1;
      redirect_to(32'h100);
      check("t3_redir_pc", pc, 32'h100);
      check("t3_redir_last", last_pc, 32'hC);
      check("t3_no_mis", {31'b0, misalign_err}, 32'd0);
      redirect_to(32'h102);
      check("t3_mis_pc", pc, 32'h4);
      check("t3_mis_pulse", {31'b0, misalign_err}, 32'd1);
      stall = 1'b0;
      tick();
      check("t3_mis_clear", {31'b0, misalign_err}, 32'd0);
      check("t3_after_pc", pc, 32'h8);
      check("t3_after_last", last_pc, 32'h4);

      // T4: trap beats redirect and accept, accept still records last_pc
      redirect_to(32'h20);
      check("t4_pc20", pc, 32'h20);
      trap_req = 1'b1;
      redirect_to(32'h200);
      trap_req = 1'b0;
      check("t4_trap_pc", pc, 32'h4);
      check("t4_trap_last", last_pc, 32'h20);

      // T5: halt with accept, frozen while halted, resume
      redirect_to(32'h30);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      check("t5_halt_pc", pc, 32'h34);
      check("t5_halted", {31'b0, halted}, 32'd1);
      check("t5_valid", {31'b0, pc_valid}, 32'd0);
      check("t5_last", last_pc, 32'h30);
      redirect_valid = 1'b1;
      redirect_tgt   = 32'h80;
      halt_req       = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t5_frozen", pc, 32'h34);
      end
      redirect_valid = 1'b0;
      resume_req = 1'b1;
      tick();
      resume_req = 1'b0;
      halt_req   = 1'b0;
      check("t5_resume_pc", pc, 32'h34);
      check("t5_resume_halted", {31'b0, halted}, 32'd0);
      check("t5_resume_valid", {31'b0, pc_valid}, 32'd1);
      tick();
      check("t5_pc38", pc, 32'h38);
      check("t5_last34", last_pc, 32'h34);
      // halt and resume together in RUN: halt wins; trap exits HALT
      halt_req = 1'b1;
      resume_req = 1'b1;
      tick();
      halt_req = 1'b0;
      resume_req = 1'b0;
      check("t5_both_halted", {31'b0, halted}, 32'd1);
      check("t5_both_pc", pc, 32'h3C);
      trap_req = 1'b1;
      tick();
      trap_req = 1'b0;
      check("t5_trap_exit_pc", pc, 32'h4);
      check("t5_trap_exit_halted", {31'b0, halted}, 32'd0);

      // T6: wrap-around and asynchronous mid-cycle reset
      redirect_to(32'hFFFF_FFFC);
      check("t6_top_pc", pc, 32'hFFFF_FFFC);
      check("t6_plus_wrap", pc_plus, 32'h0);
      tick();
      check("t6_wrap_pc", pc, 32'h0);
      check("t6_wrap_last", last_pc, 32'hFFFF_FFFC);
      tick();
      tick();
      check("t6_pc8", pc, 32'h8);
      #2;
      RST_N = 1'b0;
      #1;
      check("t6_async_pc", pc, 32'h0);
      check("t6_async_valid", {31'b0, pc_valid}, 32'd0);
      check("t6_async_last", last_pc, 32'h0);
      tick();
      RST_N = 1'b1;
      tick();
      check("t6_reboot_valid", {31'b0, pc_valid}, 32'd1);
      check("t6_reboot_pc", pc, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
